// File: rtl/grid_step_scheduler_pkg.sv
// Shared types and constants for the grid step scheduler.
// Coefficient sets are packed so they can travel on ports as single vectors.
package grid_step_scheduler_pkg;

   localparam int unsigned c_numCoefficients = 13;
   localparam int unsigned c_datawidth       = 32;

   typedef logic [c_numCoefficients-1:0][c_datawidth-1:0] t_coefficients;

   // Index 0 holds the N set and index 1 holds the N-1 set.
   typedef t_coefficients [1:0] t_coefficientSets;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_PUSH
   } t_schedState;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is visible whenever the FIFO is not empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sample_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   // Stale storage is masked so the head reads zero while empty.
   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/grid_step_scheduler.sv
// Steps the processing grid once per sample tick, owns the active/shadow coefficient sets
// and buffers grid outputs in a FIFO. Define GRID_STEP_STATS_EN to enable tick/step statistics.
module grid_step_scheduler
   import grid_step_scheduler_pkg::*;
#(
   parameter int unsigned G_NUM_COEFFS   = 13,
   parameter int unsigned G_DATA_WIDTH   = 32,
   parameter int unsigned G_FIFO_DEPTH   = 8,
   parameter int unsigned G_STEP_TIMEOUT = 4096
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_sampleTick,
   input  logic                    i_cfgValid,
   output logic                    o_cfgReady,
   input  logic                    i_cfgSel,
   input  logic [3:0]              i_cfgIndex,
   input  logic [G_DATA_WIDTH-1:0] i_cfgData,
   input  logic                    i_cfgCommit,
   output logic                    o_commitPending,
   output logic                    o_cfgError,
   output logic                    o_gridStart,
   input  logic                    i_gridReady,
   input  logic [G_DATA_WIDTH-1:0] i_gridOutput,
   output t_coefficients           o_coefficientsN,
   output t_coefficients           o_coefficientsNMinus1,
   output logic                    o_sampleValid,
   input  logic                    i_sampleReady,
   output logic [G_DATA_WIDTH-1:0] o_sample,
   output logic                    o_busy,
   output logic                    o_overrun,
   output logic                    o_fifoOverflow,
   output logic                    o_timeout,
   output logic [15:0]             o_droppedTicks,
   output logic [15:0]             o_maxStepCycles
);

   localparam int unsigned CW = $clog2(G_STEP_TIMEOUT + 1);

   t_schedState              state;
   t_schedState              state_next;
   t_coefficientSets         shadow;
   t_coefficientSets         active;
   logic                     commit_pending;
   logic                     cfg_error;
   logic                     cfg_accept;
   logic                     cfg_in_range;
   logic                     apply_commit;
   logic [CW-1:0]            step_count;
   logic [CW-1:0]            step_inc;
   logic [G_DATA_WIDTH-1:0]  sample_latched;
   logic                     grid_start;
   logic                     push;
   logic                     timeout_hit;
   logic                     tick_dropped;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     fifo_pop;
   logic                     overrun;
   logic                     fifo_overflow;
   logic                     timeout;

   // Ready is qualified by reset so every output reads zero while reset is held.
   assign o_cfgReady   = i_reset & ~commit_pending;
   assign cfg_accept   = i_cfgValid & o_cfgReady;
   assign cfg_in_range = 32'(i_cfgIndex) < G_NUM_COEFFS;
   // A commit arriving in S_IDLE is applied at once, so a same-cycle tick sees the new set.
   assign apply_commit = (commit_pending | i_cfgCommit) & (state == S_IDLE);
   assign step_inc     = step_count + CW'(1);
   assign tick_dropped = i_sampleTick & (state != S_IDLE);
   assign fifo_pop     = i_sampleReady & ~fifo_empty;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         shadow         <= '0;
         active         <= '0;
         commit_pending <= 1'b0;
         cfg_error      <= 1'b0;
      end else begin
         cfg_error <= cfg_accept & ~cfg_in_range;
         if (cfg_accept && cfg_in_range) shadow[i_cfgSel][i_cfgIndex] <= i_cfgData;
         if (apply_commit) begin
            active         <= shadow;
            commit_pending <= 1'b0;
         end else if (i_cfgCommit) begin
            commit_pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) state <= S_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next  = state;
      grid_start  = 1'b0;
      push        = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_sampleTick) state_next = S_START;
         end
         S_START: begin
            grid_start = 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            if (i_gridReady) begin
               state_next = S_PUSH;
            end else if (step_inc == CW'(G_STEP_TIMEOUT)) begin
               timeout_hit = 1'b1;
               state_next  = S_IDLE;
            end
         end
         S_PUSH: begin
            push       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         step_count     <= '0;
         sample_latched <= '0;
         overrun        <= 1'b0;
         fifo_overflow  <= 1'b0;
         timeout        <= 1'b0;
      end else begin
         if (state == S_START)     step_count <= '0;
         else if (state == S_WAIT) step_count <= step_inc;
         if (state == S_WAIT && i_gridReady) sample_latched <= i_gridOutput;
         if (tick_dropped) overrun <= 1'b1;
         if (push && fifo_full && !fifo_pop) fifo_overflow <= 1'b1;
         if (timeout_hit) timeout <= 1'b1;
      end
   end

   sample_fifo #(
      .WIDTH (G_DATA_WIDTH),
      .DEPTH (G_FIFO_DEPTH)
   ) u_fifo (
      .clk     (i_clk),
      .reset_n (i_reset),
      .push    (push),
      .wr_data (sample_latched),
      .pop     (fifo_pop),
      .rd_data (o_sample),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

`ifdef GRID_STEP_STATS_EN
   logic [15:0] dropped_ticks;
   logic [15:0] max_step;
   logic        wait_exit;

   assign wait_exit = (state == S_WAIT) && (i_gridReady || timeout_hit);

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         dropped_ticks <= '0;
         max_step      <= '0;
      end else begin
         if (tick_dropped && dropped_ticks != '1) dropped_ticks <= dropped_ticks + 16'd1;
         // step_inc counts the current S_WAIT cycle, so it is the full wait length on exit.
         if (wait_exit && 16'(step_inc) > max_step) max_step <= 16'(step_inc);
      end
   end

   assign o_droppedTicks  = dropped_ticks;
   assign o_maxStepCycles = max_step;
`else
   assign o_droppedTicks  = '0;
   assign o_maxStepCycles = '0;
`endif

   assign o_commitPending       = commit_pending;
   assign o_cfgError            = cfg_error;
   assign o_gridStart           = grid_start;
   assign o_coefficientsN       = active[0];
   assign o_coefficientsNMinus1 = active[1];
   assign o_sampleValid         = ~fifo_empty;
   assign o_busy                = (state != S_IDLE);
   assign o_overrun             = overrun;
   assign o_fifoOverflow        = fifo_overflow;
   assign o_timeout             = timeout;

endmodule

// File: tb/tb_grid_step_scheduler.sv
// Directed bench for grid_step_scheduler: inputs driven and outputs sampled on the falling edge.
module tb_grid_step_scheduler;
   import grid_step_scheduler_pkg::*;

   logic          clk;
   logic          reset;
   logic          sample_tick;
   logic          cfg_valid;
   logic          cfg_ready;
   logic          cfg_sel;
   logic [3:0]    cfg_index;
   logic [31:0]   cfg_data;
   logic          cfg_commit;
   logic          commit_pending;
   logic          cfg_error;
   logic          grid_start;
   logic          grid_ready;
   logic [31:0]   grid_output;
   t_coefficients coeff_n;
   t_coefficients coeff_m;
   logic          sample_valid;
   logic          sample_ready;
   logic [31:0]   sample;
   logic          busy;
   logic          overrun;
   logic          fifo_overflow;
   logic          timeout;
   logic [15:0]   dropped_ticks;
   logic [15:0]   max_step_cycles;

   int vectors = 0;
   int errors  = 0;

   t_coefficients sh_n;
   t_coefficients sh_m;
   t_coefficients exp_n;
   t_coefficients exp_m;

   grid_step_scheduler #(
      .G_NUM_COEFFS   (13),
      .G_DATA_WIDTH   (32),
      .G_FIFO_DEPTH   (8),
      .G_STEP_TIMEOUT (4096)
   ) dut (
      .i_clk                 (clk),
      .i_reset               (reset),
      .i_sampleTick          (sample_tick),
      .i_cfgValid            (cfg_valid),
      .o_cfgReady            (cfg_ready),
      .i_cfgSel              (cfg_sel),
      .i_cfgIndex            (cfg_index),
      .i_cfgData             (cfg_data),
      .i_cfgCommit           (cfg_commit),
      .o_commitPending       (commit_pending),
      .o_cfgError            (cfg_error),
      .o_gridStart           (grid_start),
      .i_gridReady           (grid_ready),
      .i_gridOutput          (grid_output),
      .o_coefficientsN       (coeff_n),
      .o_coefficientsNMinus1 (coeff_m),
      .o_sampleValid         (sample_valid),
      .i_sampleReady         (sample_ready),
      .o_sample              (sample),
      .o_busy                (busy),
      .o_overrun             (overrun),
      .o_fifoOverflow        (fifo_overflow),
      .o_timeout             (timeout),
      .o_droppedTicks        (dropped_ticks),
      .o_maxStepCycles       (max_step_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic adv();
      @(negedge clk);
   endtask

   task automatic write_cfg(input logic sel, input logic [3:0] idx, input logic [31:0] data);
      cfg_valid = 1'b1;
      cfg_sel   = sel;
      cfg_index = idx;
      cfg_data  = data;
      adv();
      cfg_valid = 1'b0;
      if (idx < 4'd13) begin
         if (sel) sh_m[idx] = data;
         else     sh_n[idx] = data;
      end
   endtask

   // Tick, then answer with the given sample dly cycles after the start pulse; ends back in S_IDLE.
   task automatic run_step(input logic [31:0] val, input int dly);
      sample_tick = 1'b1;
      adv();
      sample_tick = 1'b0;
      repeat (dly) adv();
      grid_ready  = 1'b1;
      grid_output = val;
      adv();
      grid_ready = 1'b0;
      adv();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      adv();
      adv();
      vectors++;
      if ({busy, grid_start, sample_valid, cfg_ready, commit_pending, cfg_error,
           overrun, fifo_overflow, timeout} !== 9'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 000000000", {busy, grid_start, sample_valid, cfg_ready,
                  commit_pending, cfg_error, overrun, fifo_overflow, timeout});
      end
      vectors++;
      if (sample !== 32'h0 || dropped_ticks !== 16'h0 || max_step_cycles !== 16'h0) begin
         errors++;
         $display("FAIL reset_data got %h/%h/%h want 0/0/0", sample, dropped_ticks, max_step_cycles);
      end
      reset = 1'b1;
      adv();
      vectors++;
      if (coeff_n !== '0 || coeff_m !== '0) begin
         errors++;
         $display("FAIL reset_coeffs got %h %h want 0", coeff_n, coeff_m);
      end
      vectors++;
      if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_ready got ready=%b busy=%b want ready=1 busy=0", cfg_ready, busy);
      end
   endtask

   task automatic test_single_step();
      sample_tick = 1'b1;
      adv();
      sample_tick = 1'b0;
      vectors++;
      if (grid_start !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL step_start got start=%b busy=%b want 1 1", grid_start, busy);
      end
      adv();
      vectors++;
      if (grid_start !== 1'b0) begin
         errors++;
         $display("FAIL step_start_pulse got %b want 0", grid_start);
      end
      repeat (4) adv();
      grid_ready  = 1'b1;
      grid_output = 32'h0001_8000;
      adv();
      grid_ready = 1'b0;
      vectors++;
      if (sample_valid !== 1'b0) begin
         errors++;
         $display("FAIL step_valid_early got %b want 0", sample_valid);
      end
      adv();
      vectors++;
      if (sample_valid !== 1'b1 || sample !== 32'h0001_8000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL step_sample got v=%b d=%h busy=%b want 1 00018000 0", sample_valid, sample, busy);
      end
      sample_ready = 1'b1;
      adv();
      sample_ready = 1'b0;
      vectors++;
      if (sample_valid !== 1'b0) begin
         errors++;
         $display("FAIL step_pop got %b want 0", sample_valid);
      end
   endtask

   task automatic test_commit();
      write_cfg(1'b0, 4'd6, 32'h0000_8026);
      write_cfg(1'b1, 4'd6, 32'hffff_00e5);
      write_cfg(1'b0, 4'd2, 32'h0000_5ff3);
      vectors++;
      if (coeff_n !== exp_n || coeff_m !== exp_m) begin
         errors++;
         $display("FAIL commit_shadow_only got %h %h want %h %h", coeff_n, coeff_m, exp_n, exp_m);
      end
      sample_tick = 1'b1;
      adv();
      sample_tick = 1'b0;
      adv();
      cfg_commit = 1'b1;
      adv();
      cfg_commit = 1'b0;
      vectors++;
      if (commit_pending !== 1'b1 || cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL commit_pending got p=%b r=%b want 1 0", commit_pending, cfg_ready);
      end
      grid_ready  = 1'b1;
      grid_output = 32'h0000_0002;
      adv();
      grid_ready = 1'b0;
      vectors++;
      if (coeff_n !== exp_n || coeff_m !== exp_m) begin
         errors++;
         $display("FAIL commit_held_in_step got %h %h want %h %h", coeff_n, coeff_m, exp_n, exp_m);
      end
      adv();
      vectors++;
      if (commit_pending !== 1'b1 || coeff_n !== exp_n) begin
         errors++;
         $display("FAIL commit_idle_before got p=%b %h want 1 %h", commit_pending, coeff_n, exp_n);
      end
      adv();
      exp_n = sh_n;
      exp_m = sh_m;
      vectors++;
      if (coeff_n !== exp_n || coeff_m !== exp_m || commit_pending !== 1'b0) begin
         errors++;
         $display("FAIL commit_applied got %h %h p=%b want %h %h 0", coeff_n, coeff_m, commit_pending,
                  exp_n, exp_m);
      end
      vectors++;
      if (sample !== 32'h0000_0002) begin
         errors++;
         $display("FAIL commit_step_sample got %h want 00000002", sample);
      end
      sample_ready = 1'b1;
      adv();
      sample_ready = 1'b0;

      write_cfg(1'b0, 4'd6, 32'h1111_1111);
      cfg_commit  = 1'b1;
      sample_tick = 1'b1;
      adv();
      cfg_commit  = 1'b0;
      sample_tick = 1'b0;
      exp_n = sh_n;
      exp_m = sh_m;
      vectors++;
      if (grid_start !== 1'b1 || coeff_n !== exp_n || coeff_m !== exp_m) begin
         errors++;
         $display("FAIL commit_with_tick got start=%b %h want 1 %h", grid_start, coeff_n, exp_n);
      end
      adv();
      grid_ready  = 1'b1;
      grid_output = 32'h0000_0003;
      adv();
      grid_ready = 1'b0;
      adv();
      vectors++;
      if (sample !== 32'h0000_0003 || sample_valid !== 1'b1) begin
         errors++;
         $display("FAIL commit_tick_sample got v=%b %h want 1 00000003", sample_valid, sample);
      end
      sample_ready = 1'b1;
      adv();
      sample_ready = 1'b0;
   endtask

   task automatic test_overrun();
      sample_tick = 1'b1;
      adv();
      sample_tick = 1'b0;
      adv();
      sample_tick = 1'b1;
      adv();
      sample_tick = 1'b0;
      vectors++;
      if (grid_start !== 1'b0 || overrun !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL overrun got start=%b ovr=%b busy=%b want 0 1 1", grid_start, overrun, busy);
      end
`ifdef GRID_STEP_STATS_EN
      vectors++;
      if (dropped_ticks !== 16'd1) begin
         errors++;
         $display("FAIL dropped_ticks got %0d want 1", dropped_ticks);
      end
`endif
      grid_ready  = 1'b1;
      grid_output = 32'h0000_0004;
      adv();
      grid_ready = 1'b0;
      adv();
      adv();
      vectors++;
      if (busy !== 1'b0 || grid_start !== 1'b0 || sample !== 32'h0000_0004) begin
         errors++;
         $display("FAIL overrun_no_replay got busy=%b start=%b %h want 0 0 00000004", busy, grid_start, sample);
      end
      sample_ready = 1'b1;
      adv();
      sample_ready = 1'b0;
   endtask

   task automatic test_fifo_overflow();
      for (int i = 1; i <= 8; i++) run_step(32'(i), 1);
      vectors++;
      if (fifo_overflow !== 1'b0) begin
         errors++;
         $display("FAIL fifo_full_no_overflow got %b want 0", fifo_overflow);
      end
      run_step(32'd9, 1);
      vectors++;
      if (fifo_overflow !== 1'b1 || sample_valid !== 1'b1) begin
         errors++;
         $display("FAIL fifo_overflow got ovf=%b v=%b want 1 1", fifo_overflow, sample_valid);
      end
      for (int i = 1; i <= 8; i++) begin
         vectors++;
         if (sample_valid !== 1'b1 || sample !== 32'(i)) begin
            errors++;
            $display("FAIL fifo_order[%0d] got v=%b %h want 1 %h", i, sample_valid, sample, 32'(i));
         end
         sample_ready = 1'b1;
         adv();
         sample_ready = 1'b0;
      end
      vectors++;
      if (sample_valid !== 1'b0) begin
         errors++;
         $display("FAIL fifo_drained got %b want 0", sample_valid);
      end
   endtask

   task automatic test_timeout();
      int cycles;
      sample_tick = 1'b1;
      adv();
      sample_tick = 1'b0;
      cycles = 0;
      while (busy === 1'b1 && cycles < 5000) begin
         adv();
         cycles++;
      end
      vectors++;
      if (cycles !== 4097) begin
         errors++;
         $display("FAIL timeout_cycles got %0d want 4097", cycles);
      end
      vectors++;
      if (timeout !== 1'b1 || sample_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_flags got to=%b v=%b busy=%b want 1 0 0", timeout, sample_valid, busy);
      end
   endtask

   task automatic test_bad_index();
      cfg_valid = 1'b1;
      cfg_sel   = 1'b0;
      cfg_index = 4'd13;
      cfg_data  = 32'hdead_beef;
      adv();
      cfg_valid = 1'b0;
      vectors++;
      if (cfg_error !== 1'b1) begin
         errors++;
         $display("FAIL cfg_error_pulse got %b want 1", cfg_error);
      end
      adv();
      vectors++;
      if (cfg_error !== 1'b0) begin
         errors++;
         $display("FAIL cfg_error_clear got %b want 0", cfg_error);
      end
      cfg_commit = 1'b1;
      adv();
      cfg_commit = 1'b0;
      vectors++;
      if (coeff_n !== exp_n || coeff_m !== exp_m) begin
         errors++;
         $display("FAIL bad_index_shadow got %h %h want %h %h", coeff_n, coeff_m, exp_n, exp_m);
      end
   endtask

   task automatic test_stats();
      vectors++;
`ifdef GRID_STEP_STATS_EN
      if (dropped_ticks !== 16'd1 || max_step_cycles !== 16'd4096) begin
         errors++;
         $display("FAIL stats got %0d %0d want 1 4096", dropped_ticks, max_step_cycles);
      end
`else
      if (dropped_ticks !== 16'd0 || max_step_cycles !== 16'd0) begin
         errors++;
         $display("FAIL stats_tied got %0d %0d want 0 0", dropped_ticks, max_step_cycles);
      end
`endif
   endtask

   task automatic test_reset_mid_step();
      sample_tick = 1'b1;
      adv();
      sample_tick = 1'b0;
      adv();
      grid_ready  = 1'b1;
      grid_output = 32'h0000_0055;
      adv();
      grid_ready = 1'b0;
      reset      = 1'b0;
      adv();
      reset = 1'b1;
      adv();
      vectors++;
      if ({busy, sample_valid, overrun, fifo_overflow, timeout} !== 5'b0 || coeff_n !== '0) begin
         errors++;
         $display("FAIL reset_mid_step got %b coeff=%h want 00000 0",
                  {busy, sample_valid, overrun, fifo_overflow, timeout}, coeff_n);
      end
   endtask

   initial begin
      reset        = 1'b0;
      sample_tick  = 1'b0;
      cfg_valid    = 1'b0;
      cfg_sel      = 1'b0;
      cfg_index    = 4'd0;
      cfg_data     = 32'h0;
      cfg_commit   = 1'b0;
      grid_ready   = 1'b0;
      grid_output  = 32'h0;
      sample_ready = 1'b0;
      sh_n  = '0;
      sh_m  = '0;
      exp_n = '0;
      exp_m = '0;

      test_reset();
      test_single_step();
      test_commit();
      test_overrun();
      test_fifo_overflow();
      test_timeout();
      test_bad_index();
      test_stats();
      test_reset_mid_step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/grid_step_scheduler.md
Name: grid_step_scheduler

Overview:
- Sequences the processing grid one time step per audio sample tick.
- Owns the active coefficient sets (N, N-1) driven into the grid, plus a host-writable shadow copy that is committed atomically between steps.
- Captures each grid output sample into an output FIFO for the audio back end.
- Sits between host config/audio timing and the processingGrid instance.

Parameters:
G_NUM_COEFFS, 13, entries per coefficient set (matches t_coefficients)
G_DATA_WIDTH, 32, sample/coefficient width, signed Q16.16
G_FIFO_DEPTH, 8, output FIFO depth, power of two
G_STEP_TIMEOUT, 4096, max cycles allowed in S_WAIT before abort

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-low reset (0 = reset)
i_sampleTick  in  1  one-cycle pulse per audio sample
i_cfgValid  in  1  coefficient write request
o_cfgReady  out  1  write accepted when high with i_cfgValid
i_cfgSel  in  1  0 = N set, 1 = N-1 set
i_cfgIndex  in  4  coefficient index
i_cfgData  in  G_DATA_WIDTH  coefficient value
i_cfgCommit  in  1  pulse: request shadow->active swap
o_commitPending  out  1  commit requested, not yet applied
o_cfgError  out  1  one-cycle pulse: index out of range
o_gridStart  out  1  one-cycle pulse starting a grid step
i_gridReady  in  1  grid output valid (grid o_outputReady)
i_gridOutput  in  G_DATA_WIDTH  grid output sample
o_coefficientsN  out  t_coefficients  active N set to grid
o_coefficientsNMinus1  out  t_coefficients  active N-1 set to grid
o_sampleValid  out  1  FIFO head valid
i_sampleReady  in  1  consumer pop
o_sample  out  G_DATA_WIDTH  FIFO head (first-word fall-through)
o_busy  out  1  state != S_IDLE
o_overrun  out  1  sticky: tick dropped while busy
o_fifoOverflow  out  1  sticky: sample dropped, FIFO full
o_timeout  out  1  sticky: step aborted by timeout

Behaviour:
- Reset (i_reset = 0 at a clock edge):
  - all outputs 0; shadow and active coefficients all 0; FIFO empty; state S_IDLE; sticky flags cleared; commit pending cleared.
- FSM states and transitions:
  - S_IDLE: if a commit is pending, apply it this cycle. Then, if i_sampleTick = 1, go to S_START.
  - S_START: o_gridStart = 1 for exactly this cycle; clear the step counter; go to S_WAIT.
  - S_WAIT: increment step counter.
    - If i_gridReady = 1: latch i_gridOutput, go to S_PUSH.
    - Else if counter reaches G_STEP_TIMEOUT: set o_timeout, go to S_IDLE with no push.
  - S_PUSH: write the latched sample to the FIFO; go to S_IDLE.
- Latency:
  - Tick at cycle t in S_IDLE gives o_gridStart at t+1.
  - i_gridReady at cycle u gives the FIFO write at u+1; o_sampleValid rises at u+2 if the FIFO was empty.
- Tick while o_busy = 1: ignored, o_overrun set.
- i_gridReady outside S_WAIT: ignored.
- Config writes:
  - o_cfgReady = !o_commitPending. A write completes on i_cfgValid & o_cfgReady and updates shadow[i_cfgSel][i_cfgIndex].
  - i_cfgIndex >= G_NUM_COEFFS: no write; o_cfgError pulses the next cycle.
- Commit:
  - i_cfgCommit sets o_commitPending.
  - The active sets are copied from shadow in the next S_IDLE cycle, which also clears pending.
  - Commit and tick in the same S_IDLE cycle: commit applies first, so the step uses the new set.
  - Active sets never change during S_START/S_WAIT/S_PUSH.
  - A commit pulse while already pending has no extra effect.
- FIFO:
  - Push when full: drop the sample, set o_fifoOverflow.
  - Simultaneous push and pop when full: both succeed.
  - Pop when empty: ignored.
- Reset mid-step: immediate return to S_IDLE; the in-flight sample is discarded.
- Sticky flags clear only on reset.

Optional Feature:
- Macro GRID_STEP_STATS_EN.
- Defined: adds o_droppedTicks (16 bit, saturating at 0xFFFF, counts ignored ticks) and o_maxStepCycles (16 bit, largest S_WAIT duration seen). Both reset to 0.
- Undefined: both ports still present, tied to 0, no counter logic.

Decomposition:
- pkg_audiovhd additions: c_numCoefficients = 13; t_schedState enum (S_IDLE, S_START, S_WAIT, S_PUSH); t_coefficientSets (2 x t_coefficients). Reuse t_coefficients and c_datawidth.
- Sub-module: sample_fifo, a synchronous first-word-fall-through FIFO with full/empty outputs, parameterised by width and depth.

Test Plan:
- Reset/idle: hold i_reset = 0 for 2 cycles, release -> all outputs 0, o_busy = 0, coefficient outputs all 0.
- Single step: tick at t; grid model asserts i_gridReady 5 cycles after o_gridStart with 0x00018000 -> o_gridStart at t+1, o_sampleValid = 1, o_sample = 0x00018000 (1.5).
- Atomic commit:
  - Write N[6] = 0x00008026, N-1[6] = 0xffff00e5, N[2] = 0x00005ff3, then commit during a step -> active sets unchanged until S_IDLE, then updated.
  - Commit and tick in the same cycle -> o_gridStart step sees the new values.
- Overrun: second tick during S_WAIT -> no extra o_gridStart, o_overrun = 1; with GRID_STEP_STATS_EN, o_droppedTicks = 1.
- FIFO overflow: i_sampleReady = 0, run 9 steps with outputs 1..9 -> o_fifoOverflow = 1; popping returns 1..8 in order.
- Timeout and bad index:
  - Never assert i_gridReady -> o_timeout = 1 after 4096 S_WAIT cycles, FSM back to S_IDLE, no sample pushed.
  - Write index 13 -> o_cfgError pulse, shadow unchanged.
